// File: rtl/serial_addsub_param.sv
// Digit-serial adder/subtractor: parallel load, LSB-first processing of DIGIT bits per
// enabled cycle, parallel result with carry, signed-overflow and a one-cycle done pulse.
module serial_addsub_param #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pload,
  input  logic             enable,
  input  logic             sub,
  input  logic [WIDTH-1:0] adata,
  input  logic [WIDTH-1:0] bdata,
  output logic [WIDTH-1:0] pout,
  output logic             cout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  // One extra count bit keeps the width legal when a single digit covers the word.
  localparam int unsigned CW   = $clog2(NDIG + 1);

  typedef enum logic [1:0] {StIdle, StLoaded, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CW-1:0]    count_q;
  logic             carry_q;

  logic [DIGIT:0]   sum;
  logic [WIDTH-1:0] shreg_nxt;
  logic             msb_cin;
  logic             last_digit;

  always_comb begin
    sum        = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
    // New digit enters at the top so the word is LSB-aligned after the final digit.
    shreg_nxt  = (shreg_q >> DIGIT) | (WIDTH'(sum[DIGIT-1:0]) << (WIDTH - DIGIT));
    // Carry into the digit's top bit recovered from its operand and sum bits.
    msb_cin    = a_q[DIGIT-1] ^ b_q[DIGIT-1] ^ sum[DIGIT-1];
    last_digit = (count_q == CW'(NDIG - 1));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      shreg_q <= '0;
      count_q <= '0;
      carry_q <= 1'b0;
      pout    <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (pload) begin
      a_q     <= adata;
      b_q     <= sub ? ~bdata : bdata;
      carry_q <= sub;
      count_q <= '0;
      state_q <= StLoaded;
      busy    <= 1'b1;
      done    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        StLoaded, StRun: begin
          if (enable) begin
            shreg_q <= shreg_nxt;
            carry_q <= sum[DIGIT];
            a_q     <= a_q >> DIGIT;
            b_q     <= b_q >> DIGIT;
            count_q <= count_q + 1'b1;
            if (last_digit) begin
              pout    <= shreg_nxt;
              cout    <= sum[DIGIT];
              ovf     <= msb_cin ^ sum[DIGIT];
              state_q <= StDone;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state_q <= StRun;
            end
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub_param.sv
// Directed bench for serial_addsub_param: a bit-serial (DIGIT=1) and a nibble-serial (DIGIT=4)
// instance share stimulus; expected values are hand-computed constants.
module tb_serial_addsub_param;

  logic       clk;
  logic       rst;
  logic       pload;
  logic       enable;
  logic       sub;
  logic [7:0] adata;
  logic [7:0] bdata;

  logic [7:0] pout1, pout4;
  logic       cout1, cout4, ovf1, ovf4, busy1, busy4, done1, done4;

  int total;
  int bad;

  serial_addsub_param #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .pload(pload), .enable(enable), .sub(sub),
    .adata(adata), .bdata(bdata), .pout(pout1), .cout(cout1), .ovf(ovf1),
    .busy(busy1), .done(done1)
  );

  serial_addsub_param #(.WIDTH(8), .DIGIT(4)) dut4 (
    .clk(clk), .rst(rst), .pload(pload), .enable(enable), .sub(sub),
    .adata(adata), .bdata(bdata), .pout(pout4), .cout(cout4), .ovf(ovf4),
    .busy(busy4), .done(done4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Load, then issue ndig enabled cycles each preceded by gap paused cycles.
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input int gap, input int ndig, input bit wide);
    pload  = 1'b1;
    adata  = a;
    bdata  = b;
    sub    = s;
    enable = 1'b0;
    step();
    pload = 1'b0;
    check("busy_after_load", wide ? busy4 : busy1, 1);
    for (int k = 0; k < ndig; k++) begin
      for (int g = 0; g < gap; g++) begin
        enable = 1'b0;
        step();
        check("busy_in_gap", wide ? busy4 : busy1, 1);
        check("done_in_gap", wide ? done4 : done1, 0);
      end
      enable = 1'b1;
      step();
      if (k < ndig - 1) check("early_done", wide ? done4 : done1, 0);
    end
    enable = 1'b0;
    check("done_pulse", wide ? done4 : done1, 1);
    check("busy_at_done", wide ? busy4 : busy1, 0);
  endtask

  task automatic after_done(input bit wide);
    enable = 1'b1;
    step();
    check("done_one_cycle", wide ? done4 : done1, 0);
    enable = 1'b0;
  endtask

  initial begin
    total  = 0;
    bad    = 0;
    rst    = 1'b0;
    pload  = 1'b0;
    enable = 1'b0;
    sub    = 1'b0;
    adata  = '0;
    bdata  = '0;
    step();
    check("rst_pout", pout1, 8'h00);
    check("rst_flags", {cout1, ovf1, busy1, done1}, 4'b0000);
    rst = 1'b1;

    enable = 1'b1;
    step();
    step();
    check("idle_enable_ignored", {busy1, done1, pout1}, 10'h000);
    enable = 1'b0;

    // 1: AA+55
    run_op(8'hAA, 8'h55, 1'b0, 0, 8, 1'b0);
    check("aa55_pout", pout1, 8'hFF);
    check("aa55_cout_ovf", {cout1, ovf1}, 2'b00);
    after_done(1'b0);
    check("aa55_hold", pout1, 8'hFF);

    // 2: carry out and signed overflow
    run_op(8'hFF, 8'h01, 1'b0, 0, 8, 1'b0);
    check("ff01_pout", pout1, 8'h00);
    check("ff01_cout_ovf", {cout1, ovf1}, 2'b10);
    after_done(1'b0);
    run_op(8'h7F, 8'h01, 1'b0, 0, 8, 1'b0);
    check("7f01_pout", pout1, 8'h80);
    check("7f01_cout_ovf", {cout1, ovf1}, 2'b01);
    after_done(1'b0);

    // 3: subtraction
    run_op(8'h05, 8'h07, 1'b1, 0, 8, 1'b0);
    check("05m07_pout", pout1, 8'hFE);
    check("05m07_cout_ovf", {cout1, ovf1}, 2'b00);
    after_done(1'b0);
    run_op(8'h80, 8'h01, 1'b1, 0, 8, 1'b0);
    check("80m01_pout", pout1, 8'h7F);
    check("80m01_cout_ovf", {cout1, ovf1}, 2'b11);
    after_done(1'b0);

    // 4: 3-cycle pauses between digits
    run_op(8'hAA, 8'h55, 1'b0, 3, 8, 1'b0);
    check("gap_pout", pout1, 8'hFF);
    check("gap_cout_ovf", {cout1, ovf1}, 2'b00);
    after_done(1'b0);

    // 5: restart with pload after four digits; old result held throughout
    pload = 1'b1; adata = 8'h05; bdata = 8'h07; sub = 1'b1;
    step();
    pload = 1'b0;
    enable = 1'b1;
    for (int k = 0; k < 4; k++) step();
    check("abort_hold_pout", pout1, 8'hFF);
    run_op(8'h10, 8'h20, 1'b0, 0, 8, 1'b0);
    check("restart_pout", pout1, 8'h30);
    check("restart_cout_ovf", {cout1, ovf1}, 2'b00);
    after_done(1'b0);

    // 6: nibble-serial instance
    run_op(8'hAA, 8'h55, 1'b0, 0, 2, 1'b1);
    check("d4_aa55_pout", pout4, 8'hFF);
    check("d4_aa55_cout_ovf", {cout4, ovf4}, 2'b00);
    after_done(1'b1);
    run_op(8'h7F, 8'h01, 1'b0, 0, 2, 1'b1);
    check("d4_7f01_pout", pout4, 8'h80);
    check("d4_7f01_cout_ovf", {cout4, ovf4}, 2'b01);
    after_done(1'b1);
    run_op(8'h80, 8'h01, 1'b1, 0, 2, 1'b1);
    check("d4_80m01_pout", pout4, 8'h7F);
    check("d4_80m01_cout_ovf", {cout4, ovf4}, 2'b11);

    // Asynchronous reset mid-run
    pload = 1'b1; adata = 8'hAA; bdata = 8'h55; sub = 1'b0;
    step();
    pload = 1'b0;
    enable = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("midrst_d1", {pout1, cout1, ovf1, busy1, done1}, 12'h000);
    check("midrst_d4", {pout4, cout4, ovf4, busy4, done4}, 12'h000);
    for (int k = 0; k < 8; k++) step();
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      step();
      check("postrst_no_done", {done1, done4, busy1, busy4}, 4'b0000);
    end
    enable = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
